// File: rtl/mips_pkg.sv
// mips_pkg: control-field widths, bit positions and default widths shared by the ID/EX stage
package mips_pkg;
  localparam int WB_W = 2;
  localparam int M_W = 3;
  localparam int EX_W = 4;
  localparam int MEMREAD_BIT = 2;
  localparam int REGWRITE_BIT = 1;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam int DEF_STALL_CNT_WIDTH = 16;
endpackage

// File: rtl/id_ex_stage_register_if.sv
// id_ex_stage_register_if: ID-stage inputs and ID/EX outputs; master = pipeline side, slave = the register
interface id_ex_stage_register_if
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int STALL_CNT_WIDTH = DEF_STALL_CNT_WIDTH
);
  logic flush_in;
  logic [REG_ADDR_WIDTH-1:0] IF_ID_RS_in, IF_ID_RT_in, IF_ID_RD_in;
  logic [WB_W-1:0] WB_in;
  logic [M_W-1:0] M_in;
  logic [EX_W-1:0] EX_in;
  logic [DATA_WIDTH-1:0] read_data_1_in, read_data_2_in, imm_in, PC_plus4_in;
  logic [WB_W-1:0] ID_EX_WB_out;
  logic [M_W-1:0] ID_EX_M_out;
  logic [EX_W-1:0] ID_EX_EX_out;
  logic [DATA_WIDTH-1:0] ID_EX_read_data_1_out, ID_EX_read_data_2_out, ID_EX_imm_out, ID_EX_PC_plus4_out;
  logic [REG_ADDR_WIDTH-1:0] ID_EX_RS_out, ID_EX_RT_out, ID_EX_RD_out;
  logic PC_write_out, IF_ID_write_out;
  logic [STALL_CNT_WIDTH-1:0] stall_count_out;
  modport master (
    output flush_in, IF_ID_RS_in, IF_ID_RT_in, IF_ID_RD_in, WB_in, M_in, EX_in,
           read_data_1_in, read_data_2_in, imm_in, PC_plus4_in,
    input  ID_EX_WB_out, ID_EX_M_out, ID_EX_EX_out, ID_EX_read_data_1_out, ID_EX_read_data_2_out,
           ID_EX_imm_out, ID_EX_PC_plus4_out, ID_EX_RS_out, ID_EX_RT_out, ID_EX_RD_out,
           PC_write_out, IF_ID_write_out, stall_count_out
  );
  modport slave (
    input  flush_in, IF_ID_RS_in, IF_ID_RT_in, IF_ID_RD_in, WB_in, M_in, EX_in,
           read_data_1_in, read_data_2_in, imm_in, PC_plus4_in,
    output ID_EX_WB_out, ID_EX_M_out, ID_EX_EX_out, ID_EX_read_data_1_out, ID_EX_read_data_2_out,
           ID_EX_imm_out, ID_EX_PC_plus4_out, ID_EX_RS_out, ID_EX_RT_out, ID_EX_RD_out,
           PC_write_out, IF_ID_write_out, stall_count_out
  );
endinterface

// File: rtl/load_use_detector.sv
// load_use_detector: flags a load in ID/EX whose nonzero destination is read by the instruction in IF/ID
module load_use_detector #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  output logic                      load_use
);
  assign load_use = mem_read && (ex_rt != '0) && (ex_rt == id_rs || ex_rt == id_rt);
endmodule

// File: rtl/id_ex_stage_register.sv
// id_ex_stage_register: ID/EX pipeline register with load-use stall, flush bubbles and a saturating stall counter
module id_ex_stage_register
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int STALL_CNT_WIDTH = DEF_STALL_CNT_WIDTH
) (
  input logic clk,
  input logic rst,
  id_ex_stage_register_if.slave bus
);
  logic load_use, bubble, count_en;
  load_use_detector #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_det (
    .mem_read(bus.ID_EX_M_out[MEMREAD_BIT]),
    .ex_rt(bus.ID_EX_RT_out),
    .id_rs(bus.IF_ID_RS_in),
    .id_rt(bus.IF_ID_RT_in),
    .load_use(load_use)
  );
  assign bubble = bus.flush_in || load_use;
  assign count_en = load_use && !bus.flush_in && !(&bus.stall_count_out);
  assign bus.PC_write_out = bus.flush_in || !load_use;
  assign bus.IF_ID_write_out = bus.flush_in || !load_use;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ID_EX_WB_out <= '0;
      bus.ID_EX_M_out <= '0;
      bus.ID_EX_EX_out <= '0;
      bus.ID_EX_read_data_1_out <= '0;
      bus.ID_EX_read_data_2_out <= '0;
      bus.ID_EX_imm_out <= '0;
      bus.ID_EX_PC_plus4_out <= '0;
      bus.ID_EX_RS_out <= '0;
      bus.ID_EX_RT_out <= '0;
      bus.ID_EX_RD_out <= '0;
      bus.stall_count_out <= '0;
    end else begin
      bus.ID_EX_WB_out <= bubble ? '0 : bus.WB_in;
      bus.ID_EX_M_out <= bubble ? '0 : bus.M_in;
      bus.ID_EX_EX_out <= bubble ? '0 : bus.EX_in;
      bus.ID_EX_read_data_1_out <= DATA_WIDTH'(bus.read_data_1_in);
      bus.ID_EX_read_data_2_out <= DATA_WIDTH'(bus.read_data_2_in);
      bus.ID_EX_imm_out <= DATA_WIDTH'(bus.imm_in);
      bus.ID_EX_PC_plus4_out <= DATA_WIDTH'(bus.PC_plus4_in);
      bus.ID_EX_RS_out <= bus.IF_ID_RS_in;
      bus.ID_EX_RT_out <= bus.IF_ID_RT_in;
      bus.ID_EX_RD_out <= bus.IF_ID_RD_in;
      bus.stall_count_out <= count_en ? bus.stall_count_out + STALL_CNT_WIDTH'(1) : bus.stall_count_out;
    end
  end
endmodule

// File: doc/id_ex_stage_register.md
ID_EX_STAGE_REGISTER -- requirements
Module: id_ex_stage_register

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the operand, immediate and PC+4 fields.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, SHALL set the width of the register-specifier fields.
REQ-003 Parameter STALL_CNT_WIDTH, default 16, SHALL set the width of the stall counter.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-006 flush_in  in  1  SHALL be the branch/jump flush request; it converts the next ID/EX entry into a bubble.
REQ-007 IF_ID_RS_in, IF_ID_RT_in, IF_ID_RD_in  in  REG_ADDR_WIDTH each  SHALL be the decoded register specifiers.
REQ-008 WB_in  in  2  SHALL carry {RegWrite, MemtoReg}.
REQ-009 M_in  in  3  SHALL carry {MemRead, MemWrite, Branch}.
REQ-010 EX_in  in  4  SHALL carry {RegDst, ALUOp[1:0], ALUSrc}.
REQ-011 read_data_1_in, read_data_2_in, imm_in, PC_plus4_in  in  DATA_WIDTH each  SHALL be the register-file outputs, sign-extended immediate and PC+4.
REQ-012 ID_EX_WB_out, ID_EX_M_out, ID_EX_EX_out  out  2/3/4  SHALL be the registered control fields.
REQ-013 ID_EX_read_data_1_out, ID_EX_read_data_2_out, ID_EX_imm_out, ID_EX_PC_plus4_out  out  DATA_WIDTH each  SHALL be the registered data fields.
REQ-014 ID_EX_RS_out, ID_EX_RT_out, ID_EX_RD_out  out  REG_ADDR_WIDTH each  SHALL be the registered specifiers; they feed the forwarding unit.
REQ-015 PC_write_out, IF_ID_write_out  out  1 each  SHALL be the write enables for the PC and the IF/ID register.
REQ-016 stall_count_out  out  STALL_CNT_WIDTH  SHALL report the number of load-use stall cycles since reset.

Function
REQ-017 load_use SHALL be computed combinationally as ID_EX_M_out[2] AND ID_EX_RT_out != 0 AND (ID_EX_RT_out == IF_ID_RS_in OR ID_EX_RT_out == IF_ID_RT_in).
REQ-018 When flush_in=1, PC_write_out and IF_ID_write_out SHALL both be 1; otherwise both SHALL equal NOT load_use.
REQ-019 Per-edge priority SHALL be rst > flush_in > load_use > normal load.
REQ-020 Normal load SHALL capture all inputs into the matching output fields, with one-cycle latency.
REQ-021 Under flush_in or load_use, the WB, M and EX fields SHALL load all zeros (bubble); data and specifier fields SHALL still load their inputs.
REQ-022 A load-use stall SHALL last exactly one cycle, because the inserted bubble has MemRead=0.
REQ-023 Back-to-back dependent loads SHALL each produce exactly one stall cycle.
REQ-024 stall_count_out SHALL increment by 1 on each edge where load_use=1 and flush_in=0, and SHALL saturate at all-ones.
REQ-025 A match on register 0 SHALL never stall.

Reset
REQ-026 When rst=1 at an edge, every registered output and stall_count_out SHALL become 0.
REQ-027 PC_write_out and IF_ID_write_out SHALL read 1 in the cycle after reset, because no load is in flight.
REQ-028 rst SHALL override flush_in and load_use on the same edge, including in the middle of a stall.

Structure
REQ-029 Package mips_pkg SHALL hold the control-field widths, the bit positions (MEMREAD_BIT=2, REGWRITE_BIT=1) and the default widths.
REQ-030 The hazard comparison SHALL be a combinational sub-module named load_use_detector.

Verification
REQ-031 Reset: assert rst for 2 cycles with nonzero inputs -> all outputs 0, PC_write_out=1, IF_ID_write_out=1, stall_count_out=0.
REQ-032 Pass-through: WB_in=2'b10, EX_in=4'b1100, RS=1, RT=2, RD=3, read_data_1_in=32'hA5A5A5A5 -> identical values on the outputs one edge later; no stall.
REQ-033 Load-use: load with RT=5 followed by an instruction with RS=5 -> PC_write_out=0 for one cycle, the next entry has all-zero control, stall_count_out=1, then PC_write_out=1.
REQ-034 Flush priority: load-use condition plus flush_in=1 -> bubble inserted, PC_write_out=1, stall_count_out unchanged.
REQ-035 R0 and saturation: load RT=0 followed by RS=0 -> no stall; with STALL_CNT_WIDTH=2, forcing 4 stalls -> stall_count_out holds at 3.
REQ-036 Reset mid-stall: rst asserted in the same cycle as load_use=1 -> outputs and counter become 0, and no stall occurs in the following cycle.
